// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss-service engine. On a miss it issues one read per
//               cycle for every word of the missing block, streams each
//               returned word into the cache data array, and writes the tag
//               array alongside the last word. fsm_busy stalls the CPU for
//               the whole fill.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  memory_read_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    input  logic                  memory_data_valid,
    input  logic [DWIDTH-1:0]     memory_data_in,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_word_addr,
    output logic [DWIDTH-1:0]     cache_data_out,
    output logic                  write_tag_array
);

    // One extra counter bit so the terminal count WORDS_PER_BLOCK fits.
    localparam int                  c_CNT_W      = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_END    = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    // Clears the byte-offset-within-block bits of an address.
    localparam logic [ADDR_WIDTH-1:0] c_BLOCK_MASK = ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [c_CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [c_CNT_W-1:0]      recv_cnt_q, recv_cnt_d;

    // Word counters scaled to byte offsets (16-bit words -> step of 2 bytes).
    logic [ADDR_WIDTH-1:0]   w_issue_off;
    logic [ADDR_WIDTH-1:0]   w_recv_off;

    assign w_issue_off = ADDR_WIDTH'(issue_cnt_q) << 1;
    assign w_recv_off  = ADDR_WIDTH'(recv_cnt_q) << 1;

    // State, block base and request/return counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Next-state and output decode; reset forces every output low at once,
    // so an aborted fill can never produce a further write or tag update.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        cache_word_addr  = '0;
        cache_data_out   = '0;
        write_tag_array  = 1'b0;

        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    // Stall in the miss cycle itself; returns are ignored here.
                    fsm_busy = miss_detected;
                    if (miss_detected) begin
                        base_d      = miss_address & c_BLOCK_MASK;
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                        state_d     = S_FILL;
                    end
                end
                S_FILL: begin
                    fsm_busy = 1'b1;
                    // Request path: back-to-back reads until the block is asked for.
                    if (issue_cnt_q < c_CNT_END) begin
                        memory_read_en = 1'b1;
                        memory_address = base_q + w_issue_off;
                        issue_cnt_d    = issue_cnt_q + c_CNT_ONE;
                    end
                    // Return path: independent of requests, words arrive in order.
                    if (memory_data_valid) begin
                        write_data_array = 1'b1;
                        cache_word_addr  = base_q + w_recv_off;
                        cache_data_out   = memory_data_in;
                        recv_cnt_d       = recv_cnt_q + c_CNT_ONE;
                        if (recv_cnt_q == c_CNT_LAST) begin
                            write_tag_array = 1'b1;
                            state_d         = S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Scoreboard bench for cache_fill_fsm. Stimulus pushes the
//               expected read requests and data/tag writes; a monitor pops
//               and compares them whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    localparam int c_AW = 16;
    localparam int c_DW = 16;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            miss_detected;
    logic [c_AW-1:0] miss_address;
    logic            fsm_busy;
    logic            memory_read_en;
    logic [c_AW-1:0] memory_address;
    logic            memory_data_valid = 1'b0;
    logic [c_DW-1:0] memory_data_in = '0;
    logic            write_data_array;
    logic [c_AW-1:0] cache_word_addr;
    logic [c_DW-1:0] cache_data_out;
    logic            write_tag_array;

    cache_fill_fsm #(
        .ADDR_WIDTH      (16),
        .DWIDTH          (16),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data_in    (memory_data_in),
        .write_data_array  (write_data_array),
        .cache_word_addr   (cache_word_addr),
        .cache_data_out    (cache_data_out),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];

    // Memory model state
    int          due_q[$];
    int          mem_lat   = 4;
    bit          gap_mode  = 1'b0;
    bit          spur_valid = 1'b0;
    logic [15:0] mem_dtag  = '0;
    logic [15:0] mem_rcnt  = '0;
    int          gi        = 0;
    int          last_due  = -100;
    int          gaps[8]   = '{1, 3, 2, 1, 2, 3, 1, 2};
    int          m0        = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Called just after a rising edge: raise the miss and queue the full fill.
    task automatic start_miss(input logic [15:0] addr, input logic [15:0] base,
                              input logic [15:0] dtag, input int lat, input bit gap);
        mem_lat  = lat;
        gap_mode = gap;
        mem_dtag = dtag;
        mem_rcnt = '0;
        gi       = 0;
        last_due = -100;
        for (int i = 0; i < 8; i++) begin
            wr_t e;
            e.addr = base + 16'(2 * i);
            e.data = dtag + 16'(i);
            e.tag  = (i == 7);
            exp_req.push_back(base + 16'(2 * i));
            exp_wr.push_back(e);
        end
        miss_detected = 1'b1;
        miss_address  = addr;
        m0            = cyc;
    endtask

    // Wait (bounded) for the last expected write, then busy must fall.
    task automatic wait_done(input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (exp_wr.size() == 0) break;
        end
        chk({nm, "_done"}, exp_wr.size(), 0);
        exp_wr.delete();
        exp_req.delete();
        due_q.delete();
        @(negedge clk);
        chk({nm, "_busy_drop"}, fsm_busy, 1'b0);
        step();
    endtask

    // Memory responder: each request returns after mem_lat cycles, optionally
    // spread out by idle gaps; spur_valid injects a stray valid pulse.
    initial begin
        forever begin
            int  due;
            logic v;
            @(negedge clk);
            if (!rst && memory_read_en) begin
                due = cyc + mem_lat;
                if (gap_mode) begin
                    if (due < last_due + 1 + gaps[gi % 8]) due = last_due + 1 + gaps[gi % 8];
                    gi++;
                end
                last_due = due;
                due_q.push_back(due);
            end
            @(posedge clk);
            #2;
            v = spur_valid;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                v = 1'b1;
                memory_data_in = mem_dtag + mem_rcnt;
                mem_rcnt++;
                void'(due_q.pop_front());
            end
            memory_data_valid = v;
        end
    end

    // Monitor: compares every presented request and write against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctrl", {28'd0, fsm_busy, memory_read_en, write_data_array, write_tag_array}, 0);
                chk("rst_addr", {memory_address, cache_word_addr}, 0);
                chk("rst_data", {16'd0, cache_data_out}, 0);
            end else begin
                if (exp_wr.size() > 0) chk("busy_held", {31'd0, fsm_busy}, 1);
                if (memory_read_en) begin
                    if (exp_req.size() == 0) chk("unexpected_req", {16'd0, memory_address}, 32'hFFFF_FFFF);
                    else chk("req_addr", {16'd0, memory_address}, {16'd0, exp_req.pop_front()});
                end
                if (write_data_array) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", {16'd0, cache_word_addr}, 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", {16'd0, cache_word_addr}, {16'd0, e.addr});
                        chk("wr_data", {16'd0, cache_data_out}, {16'd0, e.data});
                        chk("wr_tag", {31'd0, write_tag_array}, {31'd0, e.tag});
                    end
                end else if (write_tag_array) begin
                    chk("tag_without_data", 1, 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        miss_detected = 1'b1;
        miss_address  = 16'h1234;

        // Reset with a miss pending: monitor checks all outputs low.
        step();
        step();
        rst           = 1'b0;
        miss_detected = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, fsm_busy}, 0);
        chk("idle_read_en", {31'd0, memory_read_en}, 0);
        step();

        // Basic fill, latency 4, miss 0x1234 -> base 0x1230.
        start_miss(16'h1234, 16'h1230, 16'hA000, 4, 1'b0);
        step();
        miss_address = 16'h7777;            // ignored while filling
        at_neg(m0 + 1);
        chk("c1_read_en", {31'd0, memory_read_en}, 1);
        chk("c1_addr", {16'd0, memory_address}, 32'h1230);
        at_neg(m0 + 4);
        chk("c4_no_write", {31'd0, write_data_array}, 0);
        at_neg(m0 + 5);
        chk("c5_write", {31'd0, write_data_array}, 1);
        at_neg(m0 + 8);
        chk("c8_addr", {16'd0, memory_address}, 32'h123E);
        at_neg(m0 + 9);
        chk("c9_no_read", {31'd0, memory_read_en}, 0);
        step();
        miss_detected = 1'b0;
        at_neg(m0 + 11);
        chk("c11_no_tag", {31'd0, write_tag_array}, 0);
        at_neg(m0 + 12);
        chk("c12_tag", {31'd0, write_tag_array}, 1);
        chk("c12_busy", {31'd0, fsm_busy}, 1);
        at_neg(m0 + 13);
        chk("c13_busy", {31'd0, fsm_busy}, 0);
        step();

        // Stray valid while idle must not write.
        spur_valid = 1'b1;
        @(negedge clk);
        chk("spur_no_write", {31'd0, write_data_array}, 0);
        chk("spur_no_busy", {31'd0, fsm_busy}, 0);
        step();
        spur_valid = 1'b0;
        step();

        // Top-of-memory block: no wrap past 0xFFFE.
        start_miss(16'hFFFF, 16'hFFF0, 16'h5000, 3, 1'b0);
        step();
        miss_detected = 1'b0;
        wait_done("top");

        // Irregular returns with 1-3 idle cycles between words.
        start_miss(16'h2468, 16'h2460, 16'hC000, 1, 1'b1);
        step();
        miss_detected = 1'b0;
        wait_done("gaps");

        // Reset after three returned words aborts the fill.
        start_miss(16'h0500, 16'h0500, 16'hD000, 2, 1'b0);
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (exp_wr.size() <= 5) break;
        end
        chk("abort_three_words", exp_wr.size(), 5);
        step();
        rst = 1'b1;
        exp_wr.delete();
        exp_req.delete();
        due_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", {28'd0, fsm_busy, memory_read_en, write_data_array, write_tag_array}, 0);
        chk("post_rst_addr", {memory_address, cache_word_addr}, 0);
        step();

        // Fresh fill after the abort.
        start_miss(16'h0040, 16'h0040, 16'hE000, 4, 1'b0);
        step();
        miss_detected = 1'b0;
        wait_done("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
